rf_write_arbiter: RTL and testbench

Shares the single register-file write port between two writers. The pipeline writeback stage cannot stall. A multi-cycle unit (divider/load miss) uses a valid/ready handshake, and its results queue in a DEPTH-entry FIFO that drains into idle write slots. The block also provides pending-write lookup for the issue-stage hazard logic and a starvation stall request to the pipeline.

---
 rtl/rf_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the non-stallable
//   writeback stage and a multi-cycle unit whose results are buffered in a
//   DEPTH-entry FIFO that drains into idle write slots. The block also
//   provides pending-write lookup for issue-stage hazard detection and
//   requests a pipeline bubble when queued results are starved.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_wdata    writeback request (always wins; rd=0 ignored)
//   mcu_valid/mcu_rd/mcu_wdata    multi-cycle result, handshaked by mcu_ready
//   mcu_ready                     FIFO has room (no credit for same-cycle pop)
//   q_rs1/q_rs2, q_hit1/q_hit2    combinational pending-write lookup
//   pipe_stall                    registered starvation bubble request
//   rf_we/rf_rd/rf_wdata          registered register-file write port
module rf_write_arbiter #(
    parameter int unsigned N            = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_we,
    input  logic [4:0]   pipe_rd,
    input  logic [N-1:0] pipe_wdata,
    input  logic         mcu_valid,
    input  logic [4:0]   mcu_rd,
    input  logic [N-1:0] mcu_wdata,
    output logic         mcu_ready,
    input  logic [4:0]   q_rs1,
    input  logic [4:0]   q_rs2,
    output logic         q_hit1,
    output logic         q_hit2,
    output logic         pipe_stall,
    output logic         rf_we,
    output logic [4:0]   rf_rd,
    output logic [N-1:0] rf_wdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIM  = CW'(STARVE_LIMIT);

    logic [4:0]       ent_rd_q   [DEPTH];
    logic [N-1:0]     ent_data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [N-1:0]     rf_wdata_q, rf_wdata_d;

    logic pipe_win, fifo_empty, pop, enq, enq_live;

    assign pipe_win   = pipe_we && (pipe_rd != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign pop        = !pipe_win && !fifo_empty;
    assign mcu_ready  = !rst && (count_q < FULL);
    assign enq        = mcu_valid && mcu_ready && (mcu_rd != 5'd0);
    // A same-cycle enqueue to the pipe's rd is older than the pipe write.
    assign enq_live   = !(pipe_win && (pipe_rd == mcu_rd));

    always_comb begin
        live_d     = live_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        starve_d   = starve_q;
        stall_d    = stall_q;

        if (pipe_win) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = pipe_rd;
            rf_wdata_d = pipe_wdata;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_rd_q[i] == pipe_rd) live_d[i] = 1'b0;
            end
        end else if (pop) begin
            rf_we_d    = live_q[rd_ptr_q];
            rf_rd_d    = ent_rd_q[rd_ptr_q];
            rf_wdata_d = ent_data_q[rd_ptr_q];
        end

        // Live bits are cleared on pop so "live" always implies "occupied",
        // letting the hazard lookup ignore pointer ranges.
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + AW'(1);
        end
        if (enq) begin
            live_d[wr_ptr_q] = enq_live;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end

        case ({enq, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        // With the FIFO non-empty and no pop, the pipe necessarily won.
        if (pop || fifo_empty)  starve_d = '0;
        else if (starve_q != LIM) starve_d = starve_q + CW'(1);

        if (pop)                   stall_d = 1'b0;
        else if (starve_q == LIM)  stall_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            live_q     <= live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage needs no reset: enq is gated by mcu_ready, which is low in reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_rd_q[wr_ptr_q]   <= mcu_rd;
            ent_data_q[wr_ptr_q] <= mcu_wdata;
        end
    end

    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (ent_rd_q[i] == q_rs1)) q_hit1 = 1'b1;
            if (live_q[i] && (ent_rd_q[i] == q_rs2)) q_hit2 = 1'b1;
        end
        if (rf_we_q && (rf_rd_q == q_rs1)) q_hit1 = 1'b1;
        if (rf_we_q && (rf_rd_q == q_rs2)) q_hit2 = 1'b1;
        if (q_rs1 == 5'd0) q_hit1 = 1'b0;
        if (q_rs2 == 5'd0) q_hit2 = 1'b0;
    end

    assign pipe_stall = stall_q;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Drives rf_write_arbiter with directed scenarios and a random phase.
//   A behavioural queue model predicts each cycle's registered outputs,
//   which are pushed to a scoreboard and compared one cycle later.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst, pipe_we, mcu_valid, mcu_ready;
    logic [4:0]  pipe_rd, mcu_rd, q_rs1, q_rs2, rf_rd;
    logic [31:0] pipe_wdata, mcu_wdata, rf_wdata;
    logic        q_hit1, q_hit2, pipe_stall, rf_we;

    always #5 clk = ~clk;

    rf_write_arbiter #(.N(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .mcu_valid(mcu_valid), .mcu_rd(mcu_rd), .mcu_wdata(mcu_wdata),
        .mcu_ready(mcu_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ent_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        stall;
    } out_t;

    ent_t mq[$];
    out_t sb[$];
    logic        m_we, m_stall;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_cnt;
    bit          chk_en = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge; leaves just after the next negedge.
    task automatic cycle(input int r, input int pwe, input int prd, input int pd,
                         input int mv, input int mrd, input int md,
                         input int rs1, input int rs2);
        out_t e;
        ent_t h;
        bit   pw, pop, empty, ready, hit1, hit2, new_stall;

        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rf_we",      32'(rf_we),      32'(e.we));
            check("rf_rd",      32'(rf_rd),      32'(e.rd));
            check("rf_wdata",   rf_wdata,        e.data);
            check("pipe_stall", 32'(pipe_stall), 32'(e.stall));
        end

        rst        = (r != 0);
        pipe_we    = (pwe != 0);
        pipe_rd    = prd[4:0];
        pipe_wdata = pd;
        mcu_valid  = (mv != 0);
        mcu_rd     = mrd[4:0];
        mcu_wdata  = md;
        q_rs1      = rs1[4:0];
        q_rs2      = rs2[4:0];
        #1;

        ready = !rst && (mq.size() < 4);
        hit1  = 1'b0;
        hit2  = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].rd == q_rs1) hit1 = 1'b1;
            if (mq[i].live && mq[i].rd == q_rs2) hit2 = 1'b1;
        end
        if (m_we && m_rd == q_rs1) hit1 = 1'b1;
        if (m_we && m_rd == q_rs2) hit2 = 1'b1;
        if (q_rs1 == 5'd0) hit1 = 1'b0;
        if (q_rs2 == 5'd0) hit2 = 1'b0;

        if (chk_en) begin
            check("mcu_ready", 32'(mcu_ready), 32'(ready));
            check("q_hit1",    32'(q_hit1),    32'(hit1));
            check("q_hit2",    32'(q_hit2),    32'(hit2));
        end

        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_rd = '0; m_data = '0; m_stall = 1'b0; m_cnt = 0;
        end else begin
            pw    = pipe_we && (pipe_rd != 5'd0);
            empty = (mq.size() == 0);
            pop   = !pw && !empty;
            new_stall = pop ? 1'b0 : ((m_cnt == 8) ? 1'b1 : m_stall);
            if (pop || empty) m_cnt = 0;
            else if (m_cnt < 8) m_cnt++;
            if (pw) begin
                m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_wdata;
                foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
            end else if (pop) begin
                h = mq.pop_front();
                m_we = h.live; m_rd = h.rd; m_data = h.data;
            end else begin
                m_we = 1'b0;
            end
            if (mcu_valid && ready && mcu_rd != 5'd0) begin
                h.rd   = mcu_rd;
                h.data = mcu_wdata;
                h.live = !(pw && pipe_rd == mcu_rd);
                mq.push_back(h);
            end
            m_stall = new_stall;
        end
        e.we = m_we; e.rd = m_rd; e.data = m_data; e.stall = m_stall;
        sb.push_back(e);
        chk_en = 1'b1;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
        mcu_valid = 1'b0; mcu_rd = '0; mcu_wdata = '0; q_rs1 = '0; q_rs2 = '0;

        // Reset with a valid multi-cycle result presented
        cycle(1, 0, 0, 0, 1, 3, 32'h55, 3, 0);
        cycle(1, 0, 0, 0, 1, 3, 32'h55, 3, 0);
        check("rst_ready", 32'(mcu_ready), 0);
        check("rst_we",    32'(rf_we),     0);
        check("rst_wdata", rf_wdata,       0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_ready", 32'(mcu_ready), 1);
        check("post_rst_we",    32'(rf_we),     0);

        // Pipe passthrough, then rd=0 treated as no request
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("pass_we",    32'(rf_we), 1);
        check("pass_rd",    32'(rf_rd), 5);
        check("pass_wdata", rf_wdata,   32'hDEADBEEF);
        cycle(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
        check("x0_we", 32'(rf_we), 0);

        // Drain order with pipe idle
        cycle(0, 0, 0, 0, 1, 3, 32'h11, 0, 0);
        cycle(0, 0, 0, 0, 1, 4, 32'h22, 0, 0);
        cycle(0, 0, 0, 0, 1, 7, 32'h33, 0, 0);
        idle(4);

        // Fill while pipe busy; ready drops after fourth accept
        cycle(0, 1, 1, 32'hA0, 1, 10, 32'h100, 10, 0);
        cycle(0, 1, 1, 32'hA1, 1, 11, 32'h101, 0, 11);
        cycle(0, 1, 1, 32'hA2, 1, 12, 32'h102, 0, 0);
        cycle(0, 1, 1, 32'hA3, 1, 13, 32'h103, 0, 0);
        check("full_ready", 32'(mcu_ready), 0);
        cycle(0, 1, 1, 32'hA4, 1, 14, 32'h104, 13, 14);
        // Pop to DEPTH-1, then simultaneous enqueue and pop
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 15, 32'h105, 0, 15);
        check("simul_ready", 32'(mcu_ready), 1);
        idle(6);

        // WAW kill of a queued entry
        cycle(0, 1, 2, 32'h2, 1, 9, 32'hAA, 9, 0);
        cycle(0, 1, 9, 32'hBB, 0, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 9, 0);
        check("waw_dead_we",   32'(rf_we),  0);
        check("waw_hit_clear", 32'(q_hit1), 0);
        // Same-cycle enqueue to the pipe's rd is stored dead
        cycle(0, 1, 20, 32'hC0, 1, 20, 32'hC1, 20, 0);
        idle(3);

        // Starvation
        cycle(0, 1, 1, 32'h1, 1, 6, 32'h66, 6, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 1, 32'h10 + i, 0, 0, 0, 0, 6);
        check("stall_high", 32'(pipe_stall), 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stall_fall", 32'(pipe_stall), 0);
        idle(2);

        // In-flight hazard and rs=0 never hits
        cycle(0, 1, 12, 32'h12, 0, 0, 0, 0, 12);
        check("inflight_hit2", 32'(q_hit2), 1);
        check("rs0_hit1",      32'(q_hit1), 0);
        idle(2);

        // Reset mid-operation discards queued results
        cycle(0, 1, 1, 32'h1, 1, 5, 32'h51, 0, 0);
        cycle(0, 1, 1, 32'h1, 1, 6, 32'h61, 5, 6);
        cycle(1, 0, 0, 0, 0, 0, 0, 5, 6);
        idle(4);

        // Random phase
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1 : 0,
                  ($urandom_range(0, 99) < 60) ? 1 : 0,
                  int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
